// File: rtl/id_ex_pkg.sv
// Shared types for the ID/EX operand stage: forwarding codes and stall FSM states.
package id_ex_pkg;

    localparam int unsigned FwdCodeWidth  = 4;
    localparam int unsigned StallCntWidth = 32;

    typedef enum logic [FwdCodeWidth-1:0] {
        FWD_RF     = 4'b0000,
        FWD_WB     = 4'b0001,
        FWD_MEM    = 4'b0010,
        FWD_LD_EX  = 4'b0011,
        FWD_LD_MEM = 4'b0100,
        FWD_EX     = 4'b1000
    } fwd_sel_e;

    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } stall_state_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand forwarding mux: picks the source named by the forwarding code and
// reports whether the value is not yet available (hazard) or the code is unknown.
module operand_fwd_mux
    import id_ex_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic [FwdCodeWidth-1:0] code_i,
    input  logic [DataWidth-1:0]    rf_data_i,
    input  logic [DataWidth-1:0]    wb_result_i,
    input  logic [DataWidth-1:0]    mem_alu_result_i,
    input  logic [DataWidth-1:0]    ex_alu_result_i,
    input  logic [DataWidth-1:0]    mem_load_data_i,
    input  logic                    mem_load_valid_i,
    output logic [DataWidth-1:0]    data_o,
    output logic                    hazard_o,
    output logic                    illegal_o
);

    // Source select; unknown codes fall back to the register file and flag illegal.
    always_comb begin
        data_o    = rf_data_i;
        hazard_o  = 1'b0;
        illegal_o = 1'b0;
        case (code_i)
            FWD_RF:     data_o = rf_data_i;
            FWD_WB:     data_o = wb_result_i;
            FWD_MEM:    data_o = mem_alu_result_i;
            FWD_EX:     data_o = ex_alu_result_i;
            FWD_LD_MEM: begin
                data_o   = mem_load_data_i;
                hazard_o = !mem_load_valid_i;
            end
            FWD_LD_EX:  hazard_o = 1'b1;
            default:    illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwards source operands, stalls decode on load-use
// hazards and registers the operands behind a valid/ready handshake.
// Optional stall-cycle counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_operand_stage
    import id_ex_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegAddrWidth = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     id_valid,
    output logic                     id_ready,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    input  logic [RegAddrWidth-1:0]  id_rd,
    output logic [RegAddrWidth-1:0]  ex_rd,
    input  logic [FwdCodeWidth-1:0]  Operand_A_control,
    input  logic [FwdCodeWidth-1:0]  Operand_B_control,
    input  logic [DataWidth-1:0]     rf_rs1_data,
    input  logic [DataWidth-1:0]     rf_rs2_data,
    input  logic [DataWidth-1:0]     ex_alu_result,
    input  logic [DataWidth-1:0]     mem_alu_result,
    input  logic [DataWidth-1:0]     wb_result,
    input  logic [DataWidth-1:0]     mem_load_data,
    input  logic                     mem_load_valid,
    output logic [DataWidth-1:0]     op_a,
    output logic [DataWidth-1:0]     op_b,
`ifdef ID_EX_STALL_CNT_EN
    input  logic                     stall_cnt_clr,
    output logic [StallCntWidth-1:0] stall_cycles,
`endif
    output logic                     illegal_fwd
);

    logic [DataWidth-1:0]    sel_a, sel_b;
    logic                    hz_a, hz_b, ill_a, ill_b;
    logic                    hz, slot_free, capture;

    logic                    ex_valid_q, ex_valid_d;
    logic [DataWidth-1:0]    op_a_q, op_a_d;
    logic [DataWidth-1:0]    op_b_q, op_b_d;
    logic [RegAddrWidth-1:0] ex_rd_q, ex_rd_d;
    logic                    illegal_q, illegal_d;
    stall_state_e            state_q;

    operand_fwd_mux #(.DataWidth(DataWidth)) u_fwd_a (
        .code_i           (Operand_A_control),
        .rf_data_i        (rf_rs1_data),
        .wb_result_i      (wb_result),
        .mem_alu_result_i (mem_alu_result),
        .ex_alu_result_i  (ex_alu_result),
        .mem_load_data_i  (mem_load_data),
        .mem_load_valid_i (mem_load_valid),
        .data_o           (sel_a),
        .hazard_o         (hz_a),
        .illegal_o        (ill_a)
    );

    operand_fwd_mux #(.DataWidth(DataWidth)) u_fwd_b (
        .code_i           (Operand_B_control),
        .rf_data_i        (rf_rs2_data),
        .wb_result_i      (wb_result),
        .mem_alu_result_i (mem_alu_result),
        .ex_alu_result_i  (ex_alu_result),
        .mem_load_data_i  (mem_load_data),
        .mem_load_valid_i (mem_load_valid),
        .data_o           (sel_b),
        .hazard_o         (hz_b),
        .illegal_o        (ill_b)
    );

    // Handshake: a hazard only matters for a real instruction; flush blocks acceptance.
    always_comb begin
        hz        = id_valid & (hz_a | hz_b);
        slot_free = !ex_valid_q | ex_ready;
        id_ready  = slot_free & !hz & !flush;
        capture   = id_valid & id_ready;
    end

    // Next-state for the ID/EX payload; flush kills the slot, backpressure holds it.
    always_comb begin
        ex_valid_d = ex_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        ex_rd_d    = ex_rd_q;
        illegal_d  = illegal_q | (id_valid & (ill_a | ill_b));
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (capture) begin
            ex_valid_d = 1'b1;
            op_a_d     = sel_a;
            op_b_d     = sel_b;
            ex_rd_d    = id_rd;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // ID/EX pipeline register and sticky illegal-code flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            ex_rd_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            ex_rd_q    <= ex_rd_d;
            illegal_q  <= illegal_d;
        end
    end

    // Stall FSM: tracks load-use wait; flush always returns to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (!flush && hz) state_q <= LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    if (flush || !hz) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [StallCntWidth-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles spent in LOAD_WAIT; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (state_q == LOAD_WAIT && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + StallCntWidth'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`endif

    assign ex_valid    = ex_valid_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign ex_rd       = ex_rd_q;
    assign illegal_fwd = illegal_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed testbench for id_ex_operand_stage with hand-computed expectations.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  id_rd;
    logic [4:0]  ex_rd;
    logic [3:0]  ca, cb;
    logic [31:0] rf1, rf2, ex_alu, mem_alu, wb, ld_data;
    logic        ld_valid;
    logic [31:0] op_a, op_b;
    logic        illegal_fwd;
`ifdef ID_EX_STALL_CNT_EN
    logic        stall_cnt_clr;
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .id_valid          (id_valid),
        .id_ready          (id_ready),
        .ex_valid          (ex_valid),
        .ex_ready          (ex_ready),
        .id_rd             (id_rd),
        .ex_rd             (ex_rd),
        .Operand_A_control (ca),
        .Operand_B_control (cb),
        .rf_rs1_data       (rf1),
        .rf_rs2_data       (rf2),
        .ex_alu_result     (ex_alu),
        .mem_alu_result    (mem_alu),
        .wb_result         (wb),
        .mem_load_data     (ld_data),
        .mem_load_valid    (ld_valid),
        .op_a              (op_a),
        .op_b              (op_b),
`ifdef ID_EX_STALL_CNT_EN
        .stall_cnt_clr     (stall_cnt_clr),
        .stall_cycles      (stall_cycles),
`endif
        .illegal_fwd       (illegal_fwd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
        id_rd = '0; ca = '0; cb = '0;
        rf1 = '0; rf2 = '0; ex_alu = '0; mem_alu = '0; wb = '0; ld_data = '0; ld_valid = 1'b0;
`ifdef ID_EX_STALL_CNT_EN
        stall_cnt_clr = 1'b0;
`endif
        #12;
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_op_a", op_a, 32'h0);
        chk("rst_op_b", op_b, 32'h0);
        chk("rst_ex_rd", 32'(ex_rd), 32'h0);
        chk("rst_illegal", 32'(illegal_fwd), 32'h0);
        rst_n = 1'b1;
        tick();

        // Plain register-file operands
        id_valid = 1'b1; ex_ready = 1'b1; rf1 = 32'h11; rf2 = 32'h22; id_rd = 5'd3;
        #1 chk("rf_id_ready", 32'(id_ready), 32'h1);
        tick();
        chk("rf_ex_valid", 32'(ex_valid), 32'h1);
        chk("rf_op_a", op_a, 32'h11);
        chk("rf_op_b", op_b, 32'h22);
        chk("rf_ex_rd", 32'(ex_rd), 32'h3);

        // EX / MEM forwarding, back-to-back with consume
        ca = 4'b1000; cb = 4'b0010; ex_alu = 32'hAA; mem_alu = 32'hBB; id_rd = 5'd4;
        #1 chk("fwd_id_ready", 32'(id_ready), 32'h1);
        tick();
        chk("fwd_op_a", op_a, 32'hAA);
        chk("fwd_op_b", op_b, 32'hBB);
        chk("fwd_ex_rd", 32'(ex_rd), 32'h4);
        chk("fwd_ex_valid", 32'(ex_valid), 32'h1);

        // Load-use: 0011 for one cycle, then 0100 without data for two cycles
        ca = 4'b0011; cb = 4'b0000; id_rd = 5'd5;
        #1 chk("ld_stall0", 32'(id_ready), 32'h0);
        tick();
        chk("ld_drained", 32'(ex_valid), 32'h0);
        chk("ld_hold_a", op_a, 32'hAA);
        ca = 4'b0100; ld_valid = 1'b0;
        #1 chk("ld_stall1", 32'(id_ready), 32'h0);
        tick();
        #1 chk("ld_stall2", 32'(id_ready), 32'h0);
        tick();
        ld_valid = 1'b1; ld_data = 32'hDEAD;
        #1 chk("ld_release", 32'(id_ready), 32'h1);
        tick();
        chk("ld_op_a", op_a, 32'hDEAD);
        chk("ld_op_b", op_b, 32'h22);
        chk("ld_ex_rd", 32'(ex_rd), 32'h5);
        chk("ld_ex_valid", 32'(ex_valid), 32'h1);
`ifdef ID_EX_STALL_CNT_EN
        chk("ld_stall_cycles", stall_cycles, 32'd3);
`endif

        // Backpressure for four cycles
        ca = 4'b0000; cb = 4'b0000; ld_valid = 1'b0; rf1 = 32'h33; rf2 = 32'h44; id_rd = 5'd6;
        ex_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp_id_ready", 32'(id_ready), 32'h0);
            tick();
            chk("bp_op_a", op_a, 32'hDEAD);
            chk("bp_op_b", op_b, 32'h22);
            chk("bp_ex_rd", 32'(ex_rd), 32'h5);
            chk("bp_ex_valid", 32'(ex_valid), 32'h1);
        end
        ex_ready = 1'b1;
        #1 chk("bp_release", 32'(id_ready), 32'h1);
        tick();
        chk("bp_op_a_new", op_a, 32'h33);
        chk("bp_op_b_new", op_b, 32'h44);
        chk("bp_ex_rd_new", 32'(ex_rd), 32'h6);

        // Flush while in LOAD_WAIT
        ex_ready = 1'b0; ca = 4'b0011; id_rd = 5'd7; rf1 = 32'h55;
        tick();
        chk("fl_in_wait", 32'(dut.state_q), 32'h1);
        chk("fl_valid_before", 32'(ex_valid), 32'h1);
        flush = 1'b1;
        #1 chk("fl_id_ready", 32'(id_ready), 32'h0);
        tick();
        chk("fl_ex_valid", 32'(ex_valid), 32'h0);
        chk("fl_state_run", 32'(dut.state_q), 32'h0);
        chk("fl_no_capture_a", op_a, 32'h33);
        chk("fl_no_capture_rd", 32'(ex_rd), 32'h6);
`ifdef ID_EX_STALL_CNT_EN
        chk("fl_stall_cycles", stall_cycles, 32'd4);
`endif
        flush = 1'b0; ca = 4'b0000; id_rd = 5'd8; ex_ready = 1'b1;
        tick();
        chk("post_fl_op_a", op_a, 32'h55);
        chk("post_fl_ex_rd", 32'(ex_rd), 32'h8);

        // Illegal code on operand B
        cb = 4'b0111; rf1 = 32'h77; rf2 = 32'h66; id_rd = 5'd9;
        #1 chk("ill_id_ready", 32'(id_ready), 32'h1);
        tick();
        chk("ill_op_b", op_b, 32'h66);
        chk("ill_op_a", op_a, 32'h77);
        chk("ill_flag", 32'(illegal_fwd), 32'h1);
        cb = 4'b0000; id_valid = 1'b0;
        tick();
        chk("ill_sticky", 32'(illegal_fwd), 32'h1);
        chk("ill_consumed", 32'(ex_valid), 32'h0);
        chk("ill_hold_a", op_a, 32'h77);
`ifdef ID_EX_STALL_CNT_EN
        stall_cnt_clr = 1'b1;
        tick();
        chk("cnt_clr", stall_cycles, 32'd0);
        stall_cnt_clr = 1'b0;
`endif

        // Reset in the middle of a stall
        id_valid = 1'b1; rf1 = 32'h99; id_rd = 5'd10;
        tick();
        ca = 4'b0011; ex_ready = 1'b0;
        tick();
        chk("rs_in_wait", 32'(dut.state_q), 32'h1);
        chk("rs_valid_before", 32'(ex_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rs_ex_valid", 32'(ex_valid), 32'h0);
        chk("rs_state", 32'(dut.state_q), 32'h0);
        chk("rs_illegal", 32'(illegal_fwd), 32'h0);
        chk("rs_op_a", op_a, 32'h0);
        id_valid = 1'b0;
        #10 rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Sits between decode and execute, directly downstream of the forwarding-control unit.
- Uses the per-operand 4-bit forwarding codes to pick each source operand from the register file, EX ALU result, MEM ALU result, WB result, or load return data.
- Stalls decode on load-use hazards.
- Registers the selected operands into the ID/EX pipeline register behind a valid/ready handshake.

Parameters:
- DataWidth, 32, operand/result width
- RegAddrWidth, 5, register index width

Ports:
- clk  in  1  core clock; all state rises on posedge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of the ID/EX slot (branch/trap redirect)
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts the decode instruction this cycle
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_ready  in  1  execute consumes the ID/EX contents
- id_rd  in  RegAddrWidth  destination register of the decode instruction
- ex_rd  out  RegAddrWidth  registered destination
- Operand_A_control  in  4  forwarding code for rs1
- Operand_B_control  in  4  forwarding code for rs2
- rf_rs1_data  in  DataWidth  register-file read for rs1
- rf_rs2_data  in  DataWidth  register-file read for rs2
- ex_alu_result  in  DataWidth  ALU result currently in EX
- mem_alu_result  in  DataWidth  ALU result currently in MEM
- wb_result  in  DataWidth  value being written back
- mem_load_data  in  DataWidth  data-memory read return
- mem_load_valid  in  1  mem_load_data valid this cycle
- op_a  out  DataWidth  registered operand A
- op_b  out  DataWidth  registered operand B
- illegal_fwd  out  1  sticky flag: an unsupported forwarding code was seen

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, op_a=0, op_b=0, ex_rd=0, illegal_fwd=0, FSM=RUN.
- Operand select per operand (combinational):
  - 0000 → rf data
  - 0001 → wb_result
  - 0010 → mem_alu_result
  - 1000 → ex_alu_result
  - 0100 → mem_load_data
  - 0011 → not available (hazard)
  - any other code → rf data, and set illegal_fwd (sticky until reset).
- Hazard (hz) when:
  - either code == 0011, or
  - either code == 0100 and mem_load_valid=0.
- Stall is evaluated only when id_valid=1.
- FSM states:
  - RUN:
    - id_valid & hz → LOAD_WAIT.
    - Otherwise stay in RUN.
  - LOAD_WAIT:
    - id_ready=0.
    - Stays while hz.
    - → RUN when hz clears; the capture happens in that same cycle if the slot is free.
    - flush → RUN.
- Slot free = !ex_valid | ex_ready.
- id_ready = slot_free & !hz & !flush.
- Capture on id_valid & id_ready: op_a, op_b, ex_rd load the selected values; ex_valid←1. Latency is 1 cycle from acceptance to ex_valid.
- When ex_ready & ex_valid with no new capture: ex_valid←0. op_a/op_b hold their last value.
- Backpressure (ex_valid & !ex_ready): all registers hold; id_ready=0.
- flush: ex_valid←0 next edge and no capture that cycle, with priority over capture and stall.
- Simultaneous events:
  - Consume and capture in the same cycle: ex_valid stays 1 with the new data.
  - Both operands hazarded: a single stall covers both.
- Load data arriving while the slot is blocked by backpressure is not buffered. The forwarding unit recomputes the code each cycle (the producer advances to WB → code 0001).
- Reset mid-stall returns to RUN with ex_valid=0.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles (32 bits), which increments every cycle FSM==LOAD_WAIT and saturates at all-ones.
  - Adds input stall_cnt_clr (1 bit), a synchronous clear with priority over increment.
  - Both reset to 0.
- Undefined: neither port nor the counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package id_ex_pkg holds:
  - fwd_sel_e enum: FWD_RF=4'b0000, FWD_WB=4'b0001, FWD_MEM=4'b0010, FWD_LD_EX=4'b0011, FWD_LD_MEM=4'b0100, FWD_EX=4'b1000.
  - stall_state_e {RUN, LOAD_WAIT}.
- Sub-module operand_fwd_mux is instantiated twice (A and B). It outputs the selected value, a hazard bit and an illegal bit.

Test Plan:
- Reset, then id_valid=1, both codes 0000, rf_rs1=0x11, rf_rs2=0x22, ex_ready=1 → next cycle ex_valid=1, op_a=0x11, op_b=0x22.
- A=1000 (ex_alu=0xAA), B=0010 (mem_alu=0xBB) → op_a=0xAA, op_b=0xBB captured in 1 cycle.
- A=0011 for 1 cycle, then 0100 with mem_load_valid=0 for 2 cycles, then 1 with data=0xDEAD → id_ready=0 for 3 cycles, then op_a=0xDEAD. With ID_EX_STALL_CNT_EN, stall_cycles=3.
- ex_ready=0 for 4 cycles while ex_valid=1 → op_a/op_b/ex_rd stable, id_ready=0; accepts the next instruction on the cycle ex_ready returns.
- flush asserted during LOAD_WAIT with id_valid=1 → ex_valid=0 next edge, FSM=RUN, no capture.
- Code 4'b0111 on operand B → op_b=rf_rs2_data and illegal_fwd=1, which stays 1 until rst_n=0.
